// File: rtl/serial_adder_shift.sv
// Bit-serial adder/subtractor: A and B shift LSB-first, the sum refills A, in_b refills B.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow flag output o_ovf.
module serial_adder_shift #(
    parameter int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_sub,
    input  logic [WIDTH-1:0] i_load_a,
    input  logic [WIDTH-1:0] i_load_b,
    input  logic             i_in_b,
    output logic [WIDTH-1:0] o_sum,
    output logic [WIDTH-1:0] o_b_reg,
    output logic             o_carry_out,
    output logic             o_busy,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             o_ovf,
`endif
    output logic             o_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_c;
    logic             r_sub;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic w_bx;
    logic w_s;
    logic w_cn;
    logic w_last;

    // Subtraction is A + ~B + 1: invert B bit-wise, the +1 comes from the preset carry.
    assign w_bx   = r_b[0] ^ r_sub;
    assign w_s    = r_a[0] ^ w_bx ^ r_c;
    assign w_cn   = (r_a[0] & w_bx) | (r_a[0] & r_c) | (w_bx & r_c);
    assign w_last = (r_count == CNT_W'(WIDTH - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_sub   <= 1'b0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_a     <= i_load_a;
                        r_b     <= i_load_b;
                        r_c     <= i_sub;
                        r_sub   <= i_sub;
                        r_count <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_a     <= {w_s, r_a[WIDTH-1:1]};
                    r_b     <= {i_in_b, r_b[WIDTH-1:1]};
                    r_c     <= w_cn;
                    r_count <= r_count + CNT_W'(1);
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // Signed overflow is carry into the MSB xor carry out of it.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_IDLE && i_start) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_SHIFT && w_last) begin
            r_ovf <= r_c ^ w_cn;
        end
    end

    assign o_ovf = r_ovf;
`endif

    assign o_sum       = r_a;
    assign o_b_reg     = r_b;
    assign o_carry_out = r_c;
    assign o_busy      = (r_state == ST_SHIFT);
    assign o_done      = r_done;

endmodule

// File: tb/tb_serial_adder_shift.sv
// Directed self-checking bench for serial_adder_shift at WIDTH=4.
// Overflow checks are active when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_shift;

    localparam int unsigned WIDTH = 4;

    logic             r_clk = 1'b0;
    logic             r_reset;
    logic             r_start;
    logic             r_sub;
    logic [WIDTH-1:0] r_load_a;
    logic [WIDTH-1:0] r_load_b;
    logic             r_in_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_b_reg;
    logic             w_carry_out;
    logic             w_busy;
    logic             w_done;
`ifdef SERIAL_ADDER_OVF_EN
    logic             w_ovf;
`endif

    int n_vec = 0;
    int n_err = 0;

    serial_adder_shift #(.WIDTH(WIDTH)) u_dut (
        .i_clk       (r_clk),
        .i_reset     (r_reset),
        .i_start     (r_start),
        .i_sub       (r_sub),
        .i_load_a    (r_load_a),
        .i_load_b    (r_load_b),
        .i_in_b      (r_in_b),
        .o_sum       (w_sum),
        .o_b_reg     (w_b_reg),
        .o_carry_out (w_carry_out),
        .o_busy      (w_busy),
`ifdef SERIAL_ADDER_OVF_EN
        .o_ovf       (w_ovf),
`endif
        .o_done      (w_done)
    );

    always #5 r_clk = ~r_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one operation at a negedge and watches 8 cycles; optionally pokes start mid-shift.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic sub, input logic inb, input logic [3:0] exp_sum,
                          input logic exp_c, input logic exp_ovf, input logic poke);
        int done_cyc;
        int done_cnt;
        int busy_cnt;
        done_cyc = 0;
        done_cnt = 0;
        busy_cnt = 0;
        @(negedge r_clk);
        r_start  = 1'b1;
        r_load_a = a;
        r_load_b = b;
        r_sub    = sub;
        r_in_b   = inb;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge r_clk);
            r_start = 1'b0;
            if (poke && cyc == 2) begin
                r_start  = 1'b1;
                r_load_a = 4'b1111;
                r_load_b = 4'b1111;
                r_sub    = ~sub;
            end
            if (w_busy) busy_cnt++;
            if (w_done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
        end
        check({tag, " done_cycle"}, done_cyc, 5);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " busy_cycles"}, busy_cnt, 4);
        check({tag, " sum"}, {28'd0, w_sum}, {28'd0, exp_sum});
        check({tag, " carry_out"}, {31'd0, w_carry_out}, {31'd0, exp_c});
        check({tag, " b_reg"}, {28'd0, w_b_reg}, inb ? 32'hF : 32'h0);
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, " ovf"}, {31'd0, w_ovf}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("unexpected x in expected ovf for %s", tag);
`endif
    endtask

    initial begin
        int done_seen;
        r_reset  = 1'b1;
        r_start  = 1'b0;
        r_sub    = 1'b0;
        r_load_a = '0;
        r_load_b = '0;
        r_in_b   = 1'b0;
        repeat (2) @(negedge r_clk);
        check("rst sum", {28'd0, w_sum}, 32'h0);
        check("rst b_reg", {28'd0, w_b_reg}, 32'h0);
        check("rst carry", {31'd0, w_carry_out}, 32'h0);
        check("rst busy", {31'd0, w_busy}, 32'h0);
        check("rst done", {31'd0, w_done}, 32'h0);
        r_reset = 1'b0;

        run_op("add5p7", 4'b0101, 4'b0111, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b0);
        run_op("add9p8", 4'b1001, 4'b1000, 1'b0, 1'b1, 4'b0001, 1'b1, 1'b1, 1'b0);
        run_op("sub7m5", 4'b0111, 4'b0101, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        run_op("sub5m7", 4'b0101, 4'b0111, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
        run_op("add7p1", 4'b0111, 4'b0001, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);
        run_op("addFp1", 4'b1111, 4'b0001, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        run_op("poke", 4'b0101, 4'b0111, 1'b0, 1'b0, 4'b1100, 1'b0, 1'b1, 1'b1);

        // Abort after the second shift edge.
        @(negedge r_clk);
        r_start  = 1'b1;
        r_load_a = 4'b0110;
        r_load_b = 4'b0011;
        r_sub    = 1'b0;
        r_in_b   = 1'b1;
        @(negedge r_clk);
        r_start = 1'b0;
        repeat (2) @(negedge r_clk);
        check("abort busy_before", {31'd0, w_busy}, 32'h1);
        r_reset = 1'b1;
        #1;
        check("abort busy", {31'd0, w_busy}, 32'h0);
        check("abort sum", {28'd0, w_sum}, 32'h0);
        check("abort b_reg", {28'd0, w_b_reg}, 32'h0);
        check("abort carry", {31'd0, w_carry_out}, 32'h0);
        @(negedge r_clk);
        r_reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge r_clk);
            if (w_done) done_seen++;
        end
        check("abort no_done", done_seen, 0);
        check("abort idle", {31'd0, w_busy}, 32'h0);

        run_op("after_abort", 4'b0110, 4'b0011, 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
